// File: rtl/intr_generator_pkg.sv
// Shared register map, STATUS bit positions and pulse-engine state type
// for the software-driven interrupt generator.
package intr_generator_pkg;

  localparam int DEFAULT_PULSE_W = 16;

  localparam logic [2:0] REG_LEVEL_LO  = 3'd0;
  localparam logic [2:0] REG_LEVEL_HI  = 3'd1;
  localparam logic [2:0] REG_PULSE_LO  = 3'd2;
  localparam logic [2:0] REG_PULSE_HI  = 3'd3;
  localparam logic [2:0] REG_PULSE_LEN = 3'd4;
  localparam logic [2:0] REG_STATUS    = 3'd5;

  localparam int STATUS_BUSY_BIT  = 0;
  localparam int STATUS_ABORT_BIT = 0;
  localparam int STATUS_COUNT_LSB = 16;

  typedef enum logic {
    PT_IDLE   = 1'b0,
    PT_ACTIVE = 1'b1
  } pt_state_e;

endpackage

// File: rtl/intr_generator_if.sv
// Avalon-MM register port of the interrupt generator: one-wait-state
// registered read data, no wait-request.
interface intr_generator_if;
  logic [2:0]  addr;
  logic        read;
  logic        write;
  logic [31:0] wrdata;
  logic [31:0] rddata;

  modport master (output addr, read, write, wrdata, input rddata);
  modport slave  (input addr, read, write, wrdata, output rddata);
endinterface

// File: rtl/intr_pulse_timer.sv
// Shared pulse down-counter with IDLE/ACTIVE state, abort/retrigger/expiry
// priority and the completed-pulse counter.
module intr_pulse_timer
  import intr_generator_pkg::*;
#(
  parameter int PULSE_W = DEFAULT_PULSE_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fire,
  input  logic               abort,
  input  logic               clr_count,
  input  logic [PULSE_W-1:0] pulse_len,
  output logic               busy,
  output logic               clear,
  output logic [PULSE_W-1:0] count
);

  pt_state_e          state_q, state_d;
  logic [PULSE_W-1:0] cnt_q, cnt_d;
  logic [PULSE_W-1:0] count_q, count_d;
  logic               expire;

  // Priority: abort > retrigger/fire > expiry; a count clear beats an increment.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the if/else chain can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    count_d = count_q;
    clear   = 1'b0;
    expire  = (state_q == PT_ACTIVE) && (cnt_q == PULSE_W'(1));

    if (abort) begin
      state_d = PT_IDLE;
      cnt_d   = '0;
      clear   = 1'b1;
    end else if (fire) begin
      state_d = PT_ACTIVE;
      cnt_d   = (pulse_len == '0) ? PULSE_W'(1) : pulse_len;
    end else if (state_q == PT_ACTIVE) begin
      if (expire) begin
        state_d = PT_IDLE;
        cnt_d   = '0;
        clear   = 1'b1;
        count_d = count_q + PULSE_W'(1);
      end else begin
        cnt_d = cnt_q - PULSE_W'(1);
      end
    end

    if (clr_count) count_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PT_IDLE;
      cnt_q   <= '0;
      count_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
    end
  end

  assign busy  = (state_q == PT_ACTIVE);
  assign count = count_q;

endmodule

// File: rtl/intr_generator.sv
// Software-controlled interrupt source: level registers plus a shared timed
// pulse engine, driven over an Avalon-MM slave port.
module intr_generator
  import intr_generator_pkg::*;
#(
  parameter int NUM_INTR = 32,
  parameter int PULSE_W  = DEFAULT_PULSE_W
) (
  input  logic                clk,
  input  logic                rst_n,
  intr_generator_if.slave     bus,
  output logic [NUM_INTR-1:0] interrupt_out
);

  localparam int LO_W = (NUM_INTR < 32) ? NUM_INTR : 32;

  logic                wr_level_lo, wr_pulse_lo, wr_len, wr_status;
  logic [LO_W-1:0]     level_lo_q;
  logic [NUM_INTR-1:0] level_all;
  logic [31:0]         level_hi_rd;
  logic [NUM_INTR-1:0] pulse_mask;
  logic [NUM_INTR-1:0] pulse_active_q;
  logic [PULSE_W-1:0]  pulse_len_q;
  logic                fire, abort, busy, pulse_clear;
  logic [PULSE_W-1:0]  count;
  logic [PULSE_W+15:0] status_wide;
  logic [31:0]         rd_mux, rddata_q;

  assign wr_level_lo = bus.write && (bus.addr == REG_LEVEL_LO);
  assign wr_pulse_lo = bus.write && (bus.addr == REG_PULSE_LO);
  assign wr_len      = bus.write && (bus.addr == REG_PULSE_LEN);
  assign wr_status   = bus.write && (bus.addr == REG_STATUS);
  assign abort       = wr_status && bus.wrdata[STATUS_ABORT_BIT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           level_lo_q <= '0;
    else if (wr_level_lo) level_lo_q <= bus.wrdata[LO_W-1:0];
  end

  if (NUM_INTR > 32) begin : g_hi
    localparam int HI_W = NUM_INTR - 32;
    logic [HI_W-1:0] level_hi_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        level_hi_q <= '0;
      else if (bus.write && (bus.addr == REG_LEVEL_HI))
        level_hi_q <= bus.wrdata[HI_W-1:0];
    end

    assign level_all   = {level_hi_q, level_lo_q};
    assign level_hi_rd = 32'(level_hi_q);
  end else begin : g_no_hi
    assign level_all   = level_lo_q;
    assign level_hi_rd = '0;
  end

  // Per-line fire mask; lines above 31 only respond to PULSE_HI.
  for (genvar i = 0; i < NUM_INTR; i++) begin : g_mask
    if (i < 32) begin : g_lo_bit
      assign pulse_mask[i] = wr_pulse_lo && bus.wrdata[i];
    end else begin : g_hi_bit
      assign pulse_mask[i] = bus.write && (bus.addr == REG_PULSE_HI) && bus.wrdata[i-32];
    end
  end

  assign fire = |pulse_mask;

  // PULSE_LEN resets to 1 so a pulse fired straight out of reset is one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      pulse_len_q <= PULSE_W'(1);
    else if (wr_len) pulse_len_q <= bus.wrdata[PULSE_W-1:0];
  end

  intr_pulse_timer #(.PULSE_W(PULSE_W)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .fire      (fire),
    .abort     (abort),
    .clr_count (wr_status),
    .pulse_len (pulse_len_q),
    .busy      (busy),
    .clear     (pulse_clear),
    .count     (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           pulse_active_q <= '0;
    else if (pulse_clear) pulse_active_q <= '0;
    else if (fire)        pulse_active_q <= pulse_active_q | pulse_mask;
  end

  assign interrupt_out = level_all | pulse_active_q;

  assign status_wide = {count, 15'd0, busy};

  // Read mux sees pre-edge register values, so a same-cycle write is not visible.
  always_comb begin
    rd_mux = '0;
    case (bus.addr)
      REG_LEVEL_LO:  rd_mux = 32'(level_lo_q);
      REG_LEVEL_HI:  rd_mux = level_hi_rd;
      REG_PULSE_LEN: rd_mux = 32'(pulse_len_q);
      REG_STATUS:    rd_mux = 32'(status_wide);
      default:       rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rddata_q <= '0;
    else        rddata_q <= bus.read ? rd_mux : '0;
  end

  assign bus.rddata = rddata_q;

endmodule

// File: tb/tb_intr_generator.sv
// Self-checking bench: directed vector table, multi-cycle pulse corner
// sequences and randomized traffic against a deadline-based reference model.
module tb_intr_generator;
  import intr_generator_pkg::*;

  localparam logic [63:0] NMASK = (64'd1 << 40) - 64'd1;

  logic        clk;
  logic        rst_n;
  logic [39:0] out40;
  logic [31:0] out32;

  intr_generator_if bus40 ();
  intr_generator_if bus32 ();

  intr_generator #(.NUM_INTR(40), .PULSE_W(16)) dut40 (
    .clk(clk), .rst_n(rst_n), .bus(bus40), .interrupt_out(out40));
  intr_generator #(.NUM_INTR(32), .PULSE_W(16)) dut32 (
    .clk(clk), .rst_n(rst_n), .bus(bus32), .interrupt_out(out32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: absolute-time pulse deadline instead of a counter.
  logic [63:0] m_level;
  logic [63:0] m_active;
  logic [15:0] m_len;
  logic [15:0] m_count;
  logic [31:0] m_rd;
  logic [63:0] m_out;
  int          m_edge;
  int          m_end;

  typedef struct {
    bit          r;
    bit          w;
    logic [2:0]  a;
    logic [31:0] d;
    logic [63:0] eout;
    logic [31:0] erd;
    logic [31:0] eout32;
    logic [31:0] erd32;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_level  = '0;
    m_active = '0;
    m_len    = 16'd1;
    m_count  = '0;
    m_rd     = '0;
    m_out    = '0;
    m_edge   = 0;
    m_end    = 0;
  endtask

  function automatic logic [31:0] mread(input logic [2:0] a);
    case (a)
      3'd0:    return m_level[31:0];
      3'd1:    return m_level[63:32];
      3'd4:    return {16'd0, m_len};
      3'd5:    return {m_count, 15'd0, (m_active != 0)};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_edge(input bit r, input bit w, input logic [2:0] a, input logic [31:0] d);
    logic [63:0] mask;
    int          len;
    m_edge++;
    m_rd = r ? mread(a) : 32'd0;
    mask = '0;
    if (w && a == 3'd2) mask = {32'd0, d};
    if (w && a == 3'd3) mask = {d, 32'd0};
    mask &= NMASK;
    len = (m_len == 0) ? 1 : int'(m_len);
    if (w && a == 3'd5 && d[0]) begin
      m_active = '0;
    end else if (mask != 0) begin
      m_active |= mask;
      m_end = m_edge + len;
    end else if (m_active != 0 && m_edge == m_end) begin
      m_active = '0;
      m_count++;
    end
    if (w && a == 3'd5) m_count = '0;
    if (w && a == 3'd0) m_level[31:0]  = d;
    if (w && a == 3'd1) m_level[63:32] = {24'd0, d[7:0]};
    if (w && a == 3'd4) m_len = d[15:0];
    m_out = (m_level | m_active) & NMASK;
  endtask

  // One bus cycle: drive after the falling edge, check after the next one.
  task automatic step(input bit r, input bit w, input logic [2:0] a, input logic [31:0] d,
                      input bit chk);
    bus40.read = r; bus40.write = w; bus40.addr = a; bus40.wrdata = d;
    bus32.read = r; bus32.write = w; bus32.addr = a; bus32.wrdata = d;
    @(posedge clk);
    model_edge(r, w, a, d);
    @(negedge clk);
    bus40.read = 1'b0; bus40.write = 1'b0;
    bus32.read = 1'b0; bus32.write = 1'b0;
    if (chk) begin
      check("model_intr",   64'(out40), m_out);
      check("model_rddata", 64'(bus40.rddata), 64'(m_rd));
    end
  endtask

  initial begin
    int hi0, hi1, last0, last1;
    bit r, w;
    logic [2:0] a;
    logic [31:0] d;

    vecs[0]  = '{0, 1, REG_LEVEL_LO,  32'h8000_0001, 64'h00_8000_0001, 32'h0,         32'h8000_0001, 32'h0};
    vecs[1]  = '{1, 0, REG_LEVEL_LO,  32'h0,         64'h00_8000_0001, 32'h8000_0001, 32'h8000_0001, 32'h8000_0001};
    vecs[2]  = '{0, 1, REG_LEVEL_HI,  32'hFFFF_FFFF, 64'hFF_8000_0001, 32'h0,         32'h8000_0001, 32'h0};
    vecs[3]  = '{1, 0, REG_LEVEL_HI,  32'h0,         64'hFF_8000_0001, 32'hFF,        32'h8000_0001, 32'h0};
    vecs[4]  = '{1, 0, REG_PULSE_LO,  32'h0,         64'hFF_8000_0001, 32'h0,         32'h8000_0001, 32'h0};
    vecs[5]  = '{0, 1, 3'd7,          32'hFFFF_FFFF, 64'hFF_8000_0001, 32'h0,         32'h8000_0001, 32'h0};
    vecs[6]  = '{1, 0, 3'd6,          32'h0,         64'hFF_8000_0001, 32'h0,         32'h8000_0001, 32'h0};
    vecs[7]  = '{1, 0, REG_PULSE_LEN, 32'h0,         64'hFF_8000_0001, 32'h1,         32'h8000_0001, 32'h1};
    vecs[8]  = '{1, 1, REG_LEVEL_LO,  32'h5,         64'hFF_0000_0005, 32'h8000_0001, 32'h5,         32'h8000_0001};
    vecs[9]  = '{0, 1, REG_PULSE_LEN, 32'hABCD_0007, 64'hFF_0000_0005, 32'h0,         32'h5,         32'h0};
    vecs[10] = '{1, 0, REG_PULSE_LEN, 32'h0,         64'hFF_0000_0005, 32'h7,         32'h5,         32'h7};
    vecs[11] = '{1, 0, REG_STATUS,    32'h0,         64'hFF_0000_0005, 32'h0,         32'h5,         32'h0};
    vecs[12] = '{0, 1, REG_LEVEL_HI,  32'h0,         64'h00_0000_0005, 32'h0,         32'h5,         32'h0};
    vecs[13] = '{0, 1, REG_LEVEL_LO,  32'h0,         64'h0,            32'h0,         32'h0,         32'h0};

    rst_n = 1'b0;
    bus40.read = 1'b0; bus40.write = 1'b0; bus40.addr = '0; bus40.wrdata = '0;
    bus32.read = 1'b0; bus32.write = 1'b0; bus32.addr = '0; bus32.wrdata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_intr",   64'(out40), 64'h0);
    check("reset_rddata", 64'(bus40.rddata), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d, 1'b0);
      check($sformatf("vec%0d_intr", i),     64'(out40), vecs[i].eout);
      check($sformatf("vec%0d_rd", i),       64'(bus40.rddata), 64'(vecs[i].erd));
      check($sformatf("vec%0d_intr32", i),   64'(out32), 64'(vecs[i].eout32));
      check($sformatf("vec%0d_rd32", i),     64'(bus32.rddata), 64'(vecs[i].erd32));
    end

    // Five-cycle pulse on line 2, busy visible mid-pulse, count 1 afterwards.
    step(0, 1, REG_PULSE_LEN, 32'd5, 1);
    step(0, 1, REG_PULSE_LO, 32'h4, 1);
    hi0 = int'(out40[2]);
    for (int i = 0; i < 8; i++) begin
      step(i == 1, 1'b0, REG_STATUS, 32'h0, 1);
      if (i == 1) check("busy_mid_pulse", 64'(bus40.rddata[0]), 64'h1);
      hi0 += int'(out40[2]);
    end
    check("len5_high_cycles", 64'(hi0), 64'd5);
    step(1, 0, REG_STATUS, 32'h0, 1);
    check("len5_status", 64'(bus40.rddata), 64'h0001_0000);

    // Retrigger four cycles in: both lines fall together, one completion.
    step(0, 1, REG_STATUS, 32'h0, 1);
    step(0, 1, REG_PULSE_LEN, 32'd10, 1);
    step(0, 1, REG_PULSE_LO, 32'h1, 1);
    hi0 = int'(out40[0]); hi1 = 0; last0 = 0; last1 = 0;
    for (int i = 1; i < 20; i++) begin
      if (i == 4) step(0, 1, REG_PULSE_LO, 32'h2, 1);
      else        step(0, 0, REG_STATUS, 32'h0, 1);
      hi0 += int'(out40[0]);
      hi1 += int'(out40[1]);
      if (out40[0]) last0 = i;
      if (out40[1]) last1 = i;
    end
    check("retrig_bit0_cycles", 64'(hi0), 64'd14);
    check("retrig_bit1_cycles", 64'(hi1), 64'd10);
    check("retrig_same_fall", 64'(last0), 64'(last1));
    step(1, 0, REG_STATUS, 32'h0, 1);
    check("retrig_status", 64'(bus40.rddata), 64'h0001_0000);

    // Abort mid-pulse.
    step(0, 1, REG_PULSE_LEN, 32'd8, 1);
    step(0, 1, REG_PULSE_LO, 32'h1, 1);
    step(0, 0, REG_STATUS, 32'h0, 1);
    step(0, 1, REG_STATUS, 32'h1, 1);
    check("abort_mid_intr", 64'(out40), 64'h0);
    step(1, 0, REG_STATUS, 32'h0, 1);
    check("abort_mid_status", 64'(bus40.rddata), 64'h0);

    // Abort exactly on the expiry edge.
    step(0, 1, REG_PULSE_LEN, 32'd3, 1);
    step(0, 1, REG_PULSE_LO, 32'h1, 1);
    step(0, 0, REG_STATUS, 32'h0, 1);
    step(0, 0, REG_STATUS, 32'h0, 1);
    step(0, 1, REG_STATUS, 32'h1, 1);
    check("abort_expiry_intr", 64'(out40), 64'h0);
    step(1, 0, REG_STATUS, 32'h0, 1);
    check("abort_expiry_status", 64'(bus40.rddata), 64'h0);

    // Retrigger exactly on the expiry edge: one completion, six high cycles.
    step(0, 1, REG_PULSE_LO, 32'h1, 1);
    hi0 = int'(out40[0]);
    step(0, 0, REG_STATUS, 32'h0, 1); hi0 += int'(out40[0]);
    step(0, 0, REG_STATUS, 32'h0, 1); hi0 += int'(out40[0]);
    step(0, 1, REG_PULSE_LO, 32'h2, 1); hi0 += int'(out40[0]);
    check("retrig_expiry_both", 64'(out40[1:0]), 64'h3);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, REG_STATUS, 32'h0, 1);
      hi0 += int'(out40[0]);
    end
    check("retrig_expiry_cycles", 64'(hi0), 64'd6);
    step(1, 0, REG_STATUS, 32'h0, 1);
    check("retrig_expiry_status", 64'(bus40.rddata), 64'h0001_0000);

    // PULSE_LEN=0 behaves as one cycle; all-zero mask does nothing.
    step(0, 1, REG_PULSE_LEN, 32'd0, 1);
    step(0, 1, REG_PULSE_HI, 32'h0, 1);
    check("zero_mask_intr", 64'(out40), 64'h0);
    step(0, 1, REG_PULSE_HI, 32'h80, 1);
    hi0 = int'(out40[39]);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, REG_STATUS, 32'h0, 1);
      hi0 += int'(out40[39]);
    end
    check("len0_high_cycles", 64'(hi0), 64'd1);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      r = 1'b0; w = 1'b0; a = 3'($urandom_range(0, 7)); d = $urandom;
      case ($urandom_range(0, 9))
        0, 1: ;
        2: begin w = 1'b1; a = REG_PULSE_LO; d = $urandom & $urandom & $urandom; end
        3: begin w = 1'b1; a = REG_PULSE_HI; d = 32'($urandom_range(0, 15)) << $urandom_range(0, 6); end
        4: begin w = 1'b1; a = REG_PULSE_LEN; d = 32'($urandom_range(0, 6)); end
        5: begin w = ($urandom_range(0, 3) == 0); a = REG_STATUS; d = 32'($urandom_range(0, 1)); end
        6: begin w = 1'b1; a = REG_LEVEL_LO; end
        7: begin w = 1'b1; a = REG_LEVEL_HI; end
        8: r = 1'b1;
        default: begin r = 1'b1; w = 1'b1; end
      endcase
      step(r, w, a, d, 1);
    end

    // Asynchronous reset in the middle of a pulse.
    step(0, 1, REG_PULSE_LEN, 32'd20, 1);
    step(0, 1, REG_LEVEL_LO, 32'h1234, 1);
    step(0, 1, REG_PULSE_LO, 32'hF0, 1);
    step(1, 0, REG_LEVEL_LO, 32'h0, 1);
    check("pre_reset_rddata", 64'(bus40.rddata), 64'h1234);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_intr",   64'(out40), 64'h0);
    check("async_reset_rddata", 64'(bus40.rddata), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(1, 0, REG_PULSE_LEN, 32'h0, 1);
    check("post_reset_len", 64'(bus40.rddata), 64'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
